// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and the init command table for the
// 16x2 character LCD refresh sequencer.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;

  localparam int LCD_COLS = 16;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    L1_ADDR,
    L1_CHAR,
    L2_ADDR,
    L2_CHAR
  } lcd_state_t;

  // Power-up command order; the clear is the slow one, covered by the 1-step EN.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = FUNC_SET;
      2'd1:    init_cmd = DISP_ON;
      2'd2:    init_cmd = CLEAR;
      default: init_cmd = ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Two-phase LCD byte strobe: phase 0 drives RS/DATA with EN high, phase 1
// drops EN while holding RS/DATA. Each phase consumes one tick.
module lcd_byte_writer (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic [7:0] LCD_DATA,
  output logic       done
);

  // Handshake: start/rs/data are sampled on a tick while EN is low (phase 0);
  // done is high on the following tick (phase 1), where the producer advances
  // and may present the next byte for the very next tick.
  assign done = tick & LCD_EN;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      LCD_EN   <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'h00;
    end else if (tick) begin
      if (LCD_EN) begin
        LCD_EN <= 1'b0;
      end else if (start) begin
        LCD_EN   <= 1'b1;
        LCD_RS   <= rs;
        LCD_DATA <= data;
      end
    end
  end

endmodule

// File: rtl/lcd_refresh_sequencer.sv
// Power-up init then two-line frame streaming for the 16x2 panel; the scene
// source supplies char_data combinationally for the registered char_addr.
module lcd_refresh_sequencer #(
  parameter int POWERUP_TICKS = 8,
  parameter bit AUTO_REFRESH  = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       refresh_req,
  input  logic [7:0] char_data,
  output logic [4:0] char_addr,
  output logic       busy,
  output logic       frame_done,
  output logic       LCD_ON,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA,
  output logic [2:0] fsm_state
);
  import lcd_pkg::*;

  localparam logic [15:0] PWR_LAST = 16'(POWERUP_TICKS - 1);
  localparam logic [3:0]  LAST_COL = 4'(LCD_COLS - 1);

  lcd_state_t  state;
  logic [15:0] pwr_cnt;
  logic [1:0]  init_idx;
  logic        req_pend;
  logic        go;
  logic        wr_start;
  logic        wr_rs;
  logic [7:0]  wr_data;
  logic        wr_done;

  assign LCD_ON    = 1'b1;
  assign LCD_RW    = 1'b0;
  assign fsm_state = state;
  assign go        = AUTO_REFRESH || req_pend;

  always_comb begin
    wr_start = 1'b1;
    wr_rs    = 1'b0;
    wr_data  = char_data;
    case (state)
      INIT:             wr_data = init_cmd(init_idx);
      L1_ADDR:          wr_data = LINE1;
      L2_ADDR:          wr_data = LINE2;
      L1_CHAR, L2_CHAR: wr_rs   = 1'b1;
      default:          wr_start = 1'b0;
    endcase
  end

  lcd_byte_writer u_writer (
    .clk      (clk),
    .resetn   (resetn),
    .tick     (tick),
    .start    (wr_start),
    .rs       (wr_rs),
    .data     (wr_data),
    .LCD_EN   (LCD_EN),
    .LCD_RS   (LCD_RS),
    .LCD_DATA (LCD_DATA),
    .done     (wr_done)
  );

  // char_addr doubles as the column counter: its low nibble wrapping ends a line.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= PWR_WAIT;
      pwr_cnt    <= '0;
      init_idx   <= '0;
      char_addr  <= '0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
      req_pend   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (refresh_req) req_pend <= 1'b1;
      if (tick) begin
        case (state)
          PWR_WAIT: begin
            if (pwr_cnt == PWR_LAST) state <= INIT;
            else pwr_cnt <= pwr_cnt + 16'd1;
          end
          INIT: begin
            if (wr_done) begin
              if (init_idx == 2'd3) begin
                if (go) begin
                  state    <= L1_ADDR;
                  req_pend <= refresh_req;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                init_idx <= init_idx + 2'd1;
              end
            end
          end
          IDLE: begin
            if (req_pend) begin
              state    <= L1_ADDR;
              busy     <= 1'b1;
              req_pend <= refresh_req;
            end
          end
          L1_ADDR: if (wr_done) state <= L1_CHAR;
          L1_CHAR: begin
            if (wr_done) begin
              char_addr <= char_addr + 5'd1;
              if (char_addr[3:0] == LAST_COL) state <= L2_ADDR;
            end
          end
          L2_ADDR: if (wr_done) state <= L2_CHAR;
          L2_CHAR: begin
            if (wr_done) begin
              char_addr <= char_addr + 5'd1;
              if (char_addr[3:0] == LAST_COL) begin
                frame_done <= 1'b1;
                if (go) begin
                  state    <= L1_ADDR;
                  req_pend <= refresh_req;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          default: state <= PWR_WAIT;
        endcase
      end
    end
  end

endmodule
